// File: rtl/n64_cart_pkg.sv
// Shared types and defaults for the N64 cartridge bus to SDRAM bridge.
package n64_cart_pkg;

    typedef logic [31:0] cart_addr_t;

    localparam cart_addr_t DEFAULT_ROM_BASE  = 32'h1000_0000;
    localparam cart_addr_t DEFAULT_ADDR_MASK = 32'h01FF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_WAIT,
        ST_PREFETCH,
        ST_READY,
        ST_DRIVE,
        ST_WRITE_REQ
    } state_t;

    function automatic cart_addr_t map_addr(input cart_addr_t a,
                                            input cart_addr_t base,
                                            input cart_addr_t mask);
        return (a - base) & mask;
    endfunction

endpackage

// File: rtl/cart_sync.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized output.
module cart_sync #(
    parameter int unsigned      WIDTH    = 1,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;
    logic [WIDTH-1:0]             q_d;

    if (STAGES > 1) begin : g_shift
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) pipe <= {STAGES{IDLE_VAL}};
            else      pipe <= {pipe[STAGES-2:0], d};
        end
    end else begin : g_single
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) pipe <= IDLE_VAL;
            else      pipe <= d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_d <= IDLE_VAL;
        else      q_d <= pipe[STAGES-1];
    end

    assign q    = pipe[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/n64_cart_bus_bridge.sv
// Bridges the asynchronous N64 cartridge AD bus onto single-outstanding SDRAM read/write ports.
module n64_cart_bus_bridge
    import n64_cart_pkg::*;
#(
    parameter cart_addr_t  ROM_BASE    = DEFAULT_ROM_BASE,
    parameter cart_addr_t  ADDR_MASK   = DEFAULT_ADDR_MASK,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cart_ad_in,
    output logic [15:0] cart_ad_out,
    output logic        cart_ad_oe,
    input  logic        cart_ale_h,
    input  logic        cart_ale_l,
    input  logic        cart_read_n,
    input  logic        cart_write_n,
    output logic        readport_rd,
    output logic [31:0] readport_addr,
    input  logic [15:0] readport_data,
    input  logic        readport_ack,
    output logic        writeport_wr,
    output logic [31:0] writeport_addr,
    output logic [15:0] writeport_data,
    input  logic        writeport_ack,
    output logic        miss_err,
    output logic        wr_overrun,
    output logic        bus_conflict,
    output logic        busy
);

    logic        ale_h_fall, ale_h_q_unused, ale_h_rise_unused;
    logic        ale_l_rise, ale_l_fall, ale_l_q_unused;
    logic        rd_q, rd_rise, rd_fall;
    logic        wr_q, wr_rise, wr_fall_unused;
    logic [15:0] ad_q, ad_rise_unused, ad_fall_unused;

    cart_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_ale_h (
        .clk(clk), .rst(rst), .d(cart_ale_h),
        .q(ale_h_q_unused), .rise(ale_h_rise_unused), .fall(ale_h_fall)
    );
    cart_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_ale_l (
        .clk(clk), .rst(rst), .d(cart_ale_l),
        .q(ale_l_q_unused), .rise(ale_l_rise), .fall(ale_l_fall)
    );
    cart_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_read (
        .clk(clk), .rst(rst), .d(cart_read_n),
        .q(rd_q), .rise(rd_rise), .fall(rd_fall)
    );
    cart_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_write (
        .clk(clk), .rst(rst), .d(cart_write_n),
        .q(wr_q), .rise(wr_rise), .fall(wr_fall_unused)
    );
    cart_sync #(.WIDTH(16), .STAGES(SYNC_STAGES), .IDLE_VAL(16'h0000)) u_sync_ad (
        .clk(clk), .rst(rst), .d(cart_ad_in),
        .q(ad_q), .rise(ad_rise_unused), .fall(ad_fall_unused)
    );

    state_t      state;
    cart_addr_t  addr;
    logic [15:0] buffer;
    logic        discard;       // outstanding SDRAM request belongs to an aborted access
    logic        miss_pending;  // cart is reading zeros while the prefetch is still in flight
    logic        wr_conflict;

    logic rd_done, wr_done, fetch_hit, outstanding_next;

    always_comb begin
        rd_done          = readport_rd & readport_ack;
        wr_done          = writeport_wr & writeport_ack;
        fetch_hit        = rd_done & ~discard & (state == ST_PREFETCH);
        outstanding_next = (readport_rd & ~readport_ack) | (writeport_wr & ~writeport_ack);
    end

    assign busy = readport_rd | writeport_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            addr           <= '0;
            buffer         <= '0;
            discard        <= 1'b0;
            miss_pending   <= 1'b0;
            wr_conflict    <= 1'b0;
            cart_ad_out    <= '0;
            cart_ad_oe     <= 1'b0;
            readport_rd    <= 1'b0;
            readport_addr  <= '0;
            writeport_wr   <= 1'b0;
            writeport_addr <= '0;
            writeport_data <= '0;
            miss_err       <= 1'b0;
            wr_overrun     <= 1'b0;
            bus_conflict   <= 1'b0;
        end else begin
            // SDRAM completions
            if (rd_done) begin
                readport_rd <= 1'b0;
                discard     <= 1'b0;
                if (fetch_hit) begin
                    buffer <= readport_data;
                    if (miss_pending) begin
                        cart_ad_out  <= readport_data;
                        miss_pending <= 1'b0;
                        state        <= ST_DRIVE;
                    end else begin
                        state <= ST_READY;
                    end
                end
            end
            if (wr_done) begin
                writeport_wr <= 1'b0;
                discard      <= 1'b0;
                if (!discard && state == ST_WRITE_REQ) begin
                    addr  <= addr + 32'd2;
                    state <= ST_PREFETCH;
                end
            end

            if (state == ST_PREFETCH && !busy) begin
                readport_rd   <= 1'b1;
                readport_addr <= map_addr(addr, ROM_BASE, ADDR_MASK);
            end
            if (state == ST_WRITE_REQ && !busy)
                writeport_wr <= 1'b1;

            if (!rd_q && !wr_q) begin
                bus_conflict <= 1'b1;
                wr_conflict  <= 1'b1;
            end

            if (wr_rise) begin
                wr_conflict <= 1'b0;
                if (wr_conflict || !rd_q) begin
                    bus_conflict <= 1'b1;
                end else if (writeport_wr || state == ST_WRITE_REQ) begin
                    wr_overrun <= 1'b1;
                end else if (state == ST_READY || state == ST_ADDR_WAIT) begin
                    writeport_data <= ad_q;
                    writeport_addr <= map_addr(addr, ROM_BASE, ADDR_MASK);
                    state          <= ST_WRITE_REQ;
                end
            end

            if (rd_fall) begin
                if (state == ST_READY) begin
                    cart_ad_oe  <= 1'b1;
                    cart_ad_out <= buffer;
                    state       <= ST_DRIVE;
                end else if (state == ST_PREFETCH) begin
                    cart_ad_oe <= 1'b1;
                    if (fetch_hit) begin
                        cart_ad_out <= readport_data;
                        state       <= ST_DRIVE;
                    end else begin
                        cart_ad_out  <= '0;
                        miss_err     <= 1'b1;
                        miss_pending <= 1'b1;
                    end
                end
            end

            if (rd_rise) begin
                if (state == ST_DRIVE) begin
                    cart_ad_oe <= 1'b0;
                    addr       <= addr + 32'd2;
                    state      <= ST_PREFETCH;
                end else if (miss_pending) begin
                    // cart gave up on the missed word: drop its fetch and move on
                    cart_ad_oe   <= 1'b0;
                    miss_pending <= 1'b0;
                    discard      <= outstanding_next;
                    addr         <= addr + 32'd2;
                    state        <= ST_PREFETCH;
                end
            end

            if (ale_h_fall) begin
                addr[31:16]  <= ad_q;
                cart_ad_oe   <= 1'b0;
                miss_pending <= 1'b0;
                discard      <= outstanding_next;
                state        <= ST_ADDR_WAIT;
            end
            if (ale_l_rise) begin
                cart_ad_oe   <= 1'b0;
                miss_pending <= 1'b0;
                discard      <= outstanding_next;
                state        <= ST_ADDR_WAIT;
            end
            if (ale_l_fall) begin
                addr[15:0]   <= ad_q;
                cart_ad_oe   <= 1'b0;
                miss_pending <= 1'b0;
                discard      <= outstanding_next;
                state        <= ST_PREFETCH;
            end
        end
    end

endmodule

// File: tb/tb_n64_cart_bus_bridge.sv
// Directed bench for the cart bus bridge: address/read table plus burst, write, conflict, miss and reset sequences.
module tb_n64_cart_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cart_ad_in;
    logic [15:0] cart_ad_out;
    logic        cart_ad_oe;
    logic        cart_ale_h, cart_ale_l, cart_read_n, cart_write_n;
    logic        readport_rd;
    logic [31:0] readport_addr;
    logic [15:0] readport_data;
    logic        readport_ack;
    logic        writeport_wr;
    logic [31:0] writeport_addr;
    logic [15:0] writeport_data;
    logic        writeport_ack;
    logic        miss_err, wr_overrun, bus_conflict, busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    n64_cart_bus_bridge #(
        .ROM_BASE(32'h1000_0000),
        .ADDR_MASK(32'h01FF_FFFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cart_ad_in(cart_ad_in), .cart_ad_out(cart_ad_out), .cart_ad_oe(cart_ad_oe),
        .cart_ale_h(cart_ale_h), .cart_ale_l(cart_ale_l),
        .cart_read_n(cart_read_n), .cart_write_n(cart_write_n),
        .readport_rd(readport_rd), .readport_addr(readport_addr),
        .readport_data(readport_data), .readport_ack(readport_ack),
        .writeport_wr(writeport_wr), .writeport_addr(writeport_addr),
        .writeport_data(writeport_data), .writeport_ack(writeport_ack),
        .miss_err(miss_err), .wr_overrun(wr_overrun), .bus_conflict(bus_conflict), .busy(busy)
    );

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        int unsigned delay;
        logic [15:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_ale(input logic [15:0] hi, input logic [15:0] lo);
        cart_ad_in = hi; cart_ale_h = 1'b1; cart_ale_l = 1'b1;
        tick(3);
        cart_ale_h = 1'b0;
        tick(3);
        cart_ad_in = lo;
        tick(3);
        cart_ale_l = 1'b0;
        tick(3);
    endtask

    task automatic wait_rd(input string name);
        int unsigned n = 0;
        while (readport_rd !== 1'b1 && n < 64) begin tick(1); n++; end
        check(name, {31'd0, readport_rd}, 32'd1);
    endtask

    task automatic wait_wr(input string name);
        int unsigned n = 0;
        while (writeport_wr !== 1'b1 && n < 64) begin tick(1); n++; end
        check(name, {31'd0, writeport_wr}, 32'd1);
    endtask

    task automatic serve(input int unsigned delay, input logic [15:0] data);
        tick(delay);
        readport_ack = 1'b1; readport_data = data;
        tick(1);
        readport_ack = 1'b0; readport_data = 16'h0000;
    endtask

    task automatic read_pulse_low();
        cart_read_n = 1'b0;
        tick(4);
    endtask

    task automatic read_pulse_high();
        cart_read_n = 1'b1;
        tick(4);
    endtask

    initial begin
        vecs[0] = '{16'h1000, 16'h0040, 3, 16'hBEEF, 32'h0000_0040, 32'h0000_0042};
        vecs[1] = '{16'h1000, 16'h0000, 0, 16'h1111, 32'h0000_0000, 32'h0000_0002};
        vecs[2] = '{16'h11FF, 16'hFFFE, 1, 16'h2222, 32'h01FF_FFFE, 32'h0000_0000};
        vecs[3] = '{16'h0FFF, 16'hFFFE, 2, 16'h3333, 32'h01FF_FFFE, 32'h0000_0000};
        vecs[4] = '{16'h1300, 16'h1234, 5, 16'hA5A5, 32'h0100_1234, 32'h0100_1236};
        vecs[5] = '{16'h1200, 16'h0000, 7, 16'h0F0F, 32'h0000_0000, 32'h0000_0002};

        rst = 1'b0;
        cart_ad_in = 16'h0000; cart_ale_h = 1'b0; cart_ale_l = 1'b0;
        cart_read_n = 1'b1; cart_write_n = 1'b1;
        readport_data = 16'h0000; readport_ack = 1'b0; writeport_ack = 1'b0;
        tick(3);
        check("reset_oe", {31'd0, cart_ad_oe}, 32'd0);
        check("reset_rd", {31'd0, readport_rd}, 32'd0);
        check("reset_wr", {31'd0, writeport_wr}, 32'd0);
        check("reset_ad_out", {16'd0, cart_ad_out}, 32'd0);
        check("reset_flags", {29'd0, miss_err, wr_overrun, bus_conflict}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) begin
            set_ale(vecs[i].hi, vecs[i].lo);
            wait_rd($sformatf("v%0d_rd", i));
            check($sformatf("v%0d_addr", i), readport_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            tick(vecs[i].delay);
            check($sformatf("v%0d_rd_hold", i), {31'd0, readport_rd}, 32'd1);
            serve(0, vecs[i].data);
            read_pulse_low();
            check($sformatf("v%0d_oe", i), {31'd0, cart_ad_oe}, 32'd1);
            check($sformatf("v%0d_data", i), {16'd0, cart_ad_out}, {16'd0, vecs[i].data});
            check($sformatf("v%0d_miss", i), {31'd0, miss_err}, 32'd0);
            read_pulse_high();
            check($sformatf("v%0d_oe_off", i), {31'd0, cart_ad_oe}, 32'd0);
            wait_rd($sformatf("v%0d_next_rd", i));
            check($sformatf("v%0d_next_addr", i), readport_addr, vecs[i].exp_next);
            serve(0, ~vecs[i].data);
        end

        // burst of four words from the ROM base
        set_ale(16'h1000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            wait_rd($sformatf("burst%0d_rd", k));
            check($sformatf("burst%0d_addr", k), readport_addr, 32'(2 * k));
            serve(1, 16'hD000 + 16'(k));
            read_pulse_low();
            check($sformatf("burst%0d_data", k), {16'd0, cart_ad_out}, 32'hD000 + 32'(k));
            read_pulse_high();
        end
        wait_rd("burst_tail_rd");
        check("burst_tail_addr", readport_addr, 32'h0000_0008);
        serve(0, 16'h0000);
        check("burst_miss", {31'd0, miss_err}, 32'd0);

        // write with a second write_n arriving before ack
        set_ale(16'h1000, 16'h0010);
        wait_rd("wr_pre_rd");
        serve(0, 16'h5555);
        cart_ad_in = 16'h1234; cart_write_n = 1'b0;
        tick(4);
        cart_write_n = 1'b1;
        wait_wr("wr_req");
        check("wr_addr", writeport_addr, 32'h0000_0010);
        check("wr_data", {16'd0, writeport_data}, 32'h0000_1234);
        cart_ad_in = 16'h9999; cart_write_n = 1'b0;
        tick(4);
        cart_write_n = 1'b1;
        tick(4);
        check("wr_overrun", {31'd0, wr_overrun}, 32'd1);
        check("wr_hold", {31'd0, writeport_wr}, 32'd1);
        check("wr_data_kept", {16'd0, writeport_data}, 32'h0000_1234);
        writeport_ack = 1'b1;
        tick(1);
        writeport_ack = 1'b0;
        check("wr_released", {31'd0, writeport_wr}, 32'd0);
        wait_rd("wr_post_rd");
        check("wr_post_addr", readport_addr, 32'h0000_0012);
        serve(0, 16'h7777);

        // read_n and write_n low together
        cart_ad_in = 16'h4321; cart_read_n = 1'b0; cart_write_n = 1'b0;
        tick(4);
        cart_write_n = 1'b1;
        tick(4);
        check("conflict_flag", {31'd0, bus_conflict}, 32'd1);
        check("conflict_no_wr", {31'd0, writeport_wr}, 32'd0);
        check("conflict_read_data", {16'd0, cart_ad_out}, 32'h0000_7777);
        read_pulse_high();
        wait_rd("conflict_next_rd");
        check("conflict_next_addr", readport_addr, 32'h0000_0014);
        serve(0, 16'h0000);
        check("conflict_idle_busy", {31'd0, busy}, 32'd0);

        // read_n falls while the prefetch is still pending
        set_ale(16'h1000, 16'h0100);
        wait_rd("miss_rd");
        check("miss_addr", readport_addr, 32'h0000_0100);
        read_pulse_low();
        check("miss_oe", {31'd0, cart_ad_oe}, 32'd1);
        check("miss_zero", {16'd0, cart_ad_out}, 32'd0);
        check("miss_flag", {31'd0, miss_err}, 32'd1);
        tick(14);
        check("miss_rd_hold", {31'd0, readport_rd}, 32'd1);
        serve(0, 16'hCAFE);
        check("miss_late_data", {16'd0, cart_ad_out}, 32'h0000_CAFE);
        check("miss_late_oe", {31'd0, cart_ad_oe}, 32'd1);
        read_pulse_high();
        check("miss_oe_off", {31'd0, cart_ad_oe}, 32'd0);
        wait_rd("miss_next_rd");
        check("miss_next_addr", readport_addr, 32'h0000_0102);
        serve(0, 16'h0000);

        // reset while a prefetch is outstanding and oe is driven
        set_ale(16'h1000, 16'h0200);
        wait_rd("rst_pre_rd");
        read_pulse_low();
        check("rst_pre_oe", {31'd0, cart_ad_oe}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_rd", {31'd0, readport_rd}, 32'd0);
        check("rst_async_oe", {31'd0, cart_ad_oe}, 32'd0);
        check("rst_async_flags", {29'd0, miss_err, wr_overrun, bus_conflict}, 32'd0);
        cart_read_n = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        readport_ack = 1'b1; readport_data = 16'hFFFF;
        tick(1);
        readport_ack = 1'b0; readport_data = 16'h0000;
        tick(3);
        check("late_ack_rd", {31'd0, readport_rd}, 32'd0);
        check("late_ack_oe", {31'd0, cart_ad_oe}, 32'd0);
        check("late_ack_ad_out", {16'd0, cart_ad_out}, 32'd0);
        check("late_ack_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/n64_cart_bus_bridge.md
N64_CART_BUS_BRIDGE -- requirements
Module: n64_cart_bus_bridge

Interface
REQ-001 Parameter ROM_BASE, default 32'h1000_0000, cart address mapped to SDRAM offset 0.
REQ-002 Parameter ADDR_MASK, default 32'h01FF_FFFF, SDRAM offset mask (32 MB).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for all cart inputs.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 cart_ad_in  in  16  multiplexed cart AD bus, asynchronous to clk.
REQ-007 cart_ad_out  out  16  data driven to cart during reads; cart_ad_oe  out  1  AD output enable.
REQ-008 cart_ale_h, cart_ale_l, cart_read_n, cart_write_n  in  1 each  cart strobes, asynchronous.
REQ-009 readport_rd  out  1; readport_addr  out  32; readport_data  in  16; readport_ack  in  1  SDRAM read port.
REQ-010 writeport_wr  out  1; writeport_addr  out  32; writeport_data  out  16; writeport_ack  in  1  SDRAM write port.
REQ-011 miss_err, wr_overrun, bus_conflict  out  1 each  sticky error flags; busy  out  1  request outstanding.

Function
REQ-012 All cart inputs incl. cart_ad_in SHALL pass through an identical SYNC_STAGES pipeline; edges are detected on the pipeline outputs, and AD is sampled from the same-depth stage.
REQ-013 Falling edge of synced ale_h SHALL latch AD into addr[31:16]; falling edge of ale_l SHALL latch AD into addr[15:0] and enter PREFETCH.
REQ-014 Rising edge of ale_l in any state SHALL abort: oe deasserted next cycle, state ADDR_WAIT.
REQ-015 SDRAM address SHALL be (addr - ROM_BASE) & ADDR_MASK, 32-bit wrap-around arithmetic.
REQ-016 States: IDLE, ADDR_WAIT, PREFETCH, READY, DRIVE, WRITE_REQ.
REQ-017 PREFETCH: readport_rd=1 with stable addr until the cycle readport_ack=1; readport_data captured that cycle into buffer; next state READY.
REQ-018 Request rule: rd/wr SHALL never drop before ack; an aborted request completes and its data is discarded.
REQ-019 READY: read_n falling edge SHALL assert cart_ad_oe and drive buffer on cart_ad_out the following cycle; state DRIVE.
REQ-020 DRIVE: read_n rising edge SHALL deassert oe next cycle, addr += 2, return to PREFETCH for the next word.
REQ-021 Read_n falling while PREFETCH pending: drive 16'h0000 with oe=1, set miss_err; when ack arrives, drive the fetched data instead.
REQ-022 write_n rising edge in READY/ADDR_WAIT: capture synced AD, issue writeport_wr with mapped addr until writeport_ack, addr += 2, then PREFETCH.
REQ-023 write_n edge while a write is outstanding SHALL be dropped and set wr_overrun.
REQ-024 read_n and write_n simultaneously low SHALL ignore the write and set bus_conflict.
REQ-025 busy = readport_rd | writeport_wr; at most one SDRAM request outstanding.
REQ-026 Error flags clear only on reset.

Reset
REQ-027 rst low SHALL immediately force state IDLE, all outputs 0 (cart_ad_oe=0, readport_rd=0, writeport_wr=0), buffer/addr 0, flags 0, synchronizers to idle levels (strobes high, ALE low).
REQ-028 Reset mid-request SHALL drop the request; a late ack after reset release is ignored in IDLE.

Structure
REQ-029 Package n64_cart_pkg SHALL hold the state enum, ROM_BASE/ADDR_MASK defaults and the 32-bit address typedef.
REQ-030 Sub-module cart_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall edge detect, one instance per strobe and one AD-pipeline instance.

Verification
REQ-031 ALE sequence AD=16'h1000 then 16'h0040, ack after 3 cycles with data 16'hBEEF -> readport_addr=32'h0000_0040, first read_n pulse drives 16'hBEEF with oe.
REQ-032 Burst of 4 read_n pulses from 32'h1000_0000 -> readport_addr 0,2,4,6; data returned in order; no miss_err.
REQ-033 read_n falls before ack (ack delayed 20 cycles) -> AD=16'h0000, miss_err=1, then fetched data driven after ack.
REQ-034 write_n pulse with AD=16'h1234 at 32'h1000_0010 -> writeport_addr=32'h10, data 16'h1234, held until ack; second write_n before ack -> wr_overrun=1.
REQ-035 Address 32'h11FF_FFFE burst of 2 -> second readport_addr wraps to 32'h0000_0000.
REQ-036 rst asserted during PREFETCH -> rd=0, oe=0 same cycle; flags 0; late ack ignored.
